// File: rtl/qpu_exu_evt_sched.sv
// -----------------------------------------------------------------------------
// qpu_exu_evt_sched
//
// Timed event scheduler behind the execute-unit write-back ports. Time-point
// write-backs (twbck) set the current time point. Each event write-back
// (ewbck) is stamped with that time point and queued. The queue head is
// released to the quantum event output stage once the free-running system
// timer has reached its stamp. Events that go out after their stamp are
// flagged and counted.
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   twbck_i_*        time-point write-back (valid/ready/data), always ready
//   ewbck_i_*        event write-back (valid/ready/data/oprand)
//   flush_i          drops every queued event and masks this cycle's push/pop
//   evt_o_*          head event (valid/ready/data/oprand/time/late)
//   sys_time_o       free-running system timer
//   late_cnt_o       saturating count of late-issued events
//   sched_empty/full queue status
// -----------------------------------------------------------------------------
module qpu_exu_evt_sched #(
  parameter int unsigned TIME_W = 32,
  parameter int unsigned EVT_W  = 21,
  parameter int unsigned OPR_W  = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // time-point write-back
  input  logic              twbck_i_valid,
  output logic              twbck_i_ready,
  input  logic [TIME_W-1:0] twbck_i_data,
  // event write-back
  input  logic              ewbck_i_valid,
  output logic              ewbck_i_ready,
  input  logic [EVT_W-1:0]  ewbck_i_data,
  input  logic [OPR_W-1:0]  ewbck_i_oprand,
  // pipeline flush
  input  logic              flush_i,
  // event output
  output logic              evt_o_valid,
  input  logic              evt_o_ready,
  output logic [EVT_W-1:0]  evt_o_data,
  output logic [OPR_W-1:0]  evt_o_oprand,
  output logic [TIME_W-1:0] evt_o_time,
  output logic              evt_o_late,
  // status
  output logic [TIME_W-1:0] sys_time_o,
  output logic [7:0]        late_cnt_o,
  output logic              sched_empty,
  output logic              sched_full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TIME_W-1:0] sys_time_q, sys_time_d;
  logic [TIME_W-1:0] tp_q, tp_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        late_cnt_q, late_cnt_d;

  // Queue storage needs no reset: its contents are only visible when cnt_q != 0.
  logic [TIME_W-1:0] mem_time [DEPTH];
  logic [EVT_W-1:0]  mem_data [DEPTH];
  logic [OPR_W-1:0]  mem_opr  [DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [TIME_W-1:0] tp_eff;
  logic              empty, full;
  logic              push, pop;
  logic [TIME_W-1:0] head_time;
  logic [TIME_W-1:0] diff;
  logic              due, late;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);

  // A twbck in the same cycle as an ewbck stamps that event directly.
  assign tp_eff = twbck_i_valid ? twbck_i_data : tp_q;

  assign push = ewbck_i_valid & ~full & ~flush_i;

  // Modular distance from the head stamp to now. The head counts as due while
  // it lies in the past half of the time range, which keeps wrap-around safe.
  assign head_time = mem_time[rptr_q];
  assign diff      = sys_time_q - head_time;
  assign due       = ~diff[TIME_W-1];
  assign late      = due & (diff != '0);

  assign pop = evt_o_valid & evt_o_ready;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign twbck_i_ready = 1'b1;
  assign ewbck_i_ready = ~full;
  assign sched_empty   = empty;
  assign sched_full    = full;
  assign sys_time_o    = sys_time_q;
  assign late_cnt_o    = late_cnt_q;

  assign evt_o_valid  = ~empty & due & ~flush_i;
  assign evt_o_late   = evt_o_valid & late;
  assign evt_o_data   = empty ? '0 : mem_data[rptr_q];
  assign evt_o_oprand = empty ? '0 : mem_opr[rptr_q];
  assign evt_o_time   = empty ? '0 : head_time;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    sys_time_d = sys_time_q + TIME_W'(1);
    tp_d       = twbck_i_valid ? twbck_i_data : tp_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    late_cnt_d = late_cnt_q;

    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end

    if (flush_i) begin
      // Push is masked this cycle, so wptr_q is already the final tail.
      rptr_d = wptr_q;
      cnt_d  = '0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    if (pop && late && (late_cnt_q != 8'hFF)) begin
      late_cnt_d = late_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_time_q <= '0;
      tp_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      late_cnt_q <= '0;
    end else begin
      sys_time_q <= sys_time_d;
      tp_q       <= tp_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      late_cnt_q <= late_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_time[wptr_q] <= tp_eff;
      mem_data[wptr_q] <= ewbck_i_data;
      mem_opr[wptr_q]  <= ewbck_i_oprand;
    end
  end

endmodule

// File: tb/tb_qpu_exu_evt_sched.sv
// Bench for qpu_exu_evt_sched, built with an 8-bit timer so wrap-around is
// reachable in a few hundred cycles.
module tb_qpu_exu_evt_sched;

  localparam int TW    = 8;
  localparam int EW    = 21;
  localparam int OW    = 3;
  localparam int DEPTH = 4;
  localparam int TMOD  = 1 << TW;

  logic          clk;
  logic          rst_n;
  logic          twbck_i_valid, twbck_i_ready;
  logic [TW-1:0] twbck_i_data;
  logic          ewbck_i_valid, ewbck_i_ready;
  logic [EW-1:0] ewbck_i_data;
  logic [OW-1:0] ewbck_i_oprand;
  logic          flush_i;
  logic          evt_o_valid, evt_o_ready;
  logic [EW-1:0] evt_o_data;
  logic [OW-1:0] evt_o_oprand;
  logic [TW-1:0] evt_o_time;
  logic          evt_o_late;
  logic [TW-1:0] sys_time_o;
  logic [7:0]    late_cnt_o;
  logic          sched_empty, sched_full;

  qpu_exu_evt_sched #(
    .TIME_W(TW),
    .EVT_W (EW),
    .OPR_W (OW),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .twbck_i_valid (twbck_i_valid),
    .twbck_i_ready (twbck_i_ready),
    .twbck_i_data  (twbck_i_data),
    .ewbck_i_valid (ewbck_i_valid),
    .ewbck_i_ready (ewbck_i_ready),
    .ewbck_i_data  (ewbck_i_data),
    .ewbck_i_oprand(ewbck_i_oprand),
    .flush_i       (flush_i),
    .evt_o_valid   (evt_o_valid),
    .evt_o_ready   (evt_o_ready),
    .evt_o_data    (evt_o_data),
    .evt_o_oprand  (evt_o_oprand),
    .evt_o_time    (evt_o_time),
    .evt_o_late    (evt_o_late),
    .sys_time_o    (sys_time_o),
    .late_cnt_o    (late_cnt_o),
    .sched_empty   (sched_empty),
    .sched_full    (sched_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: a plain queue of stamped events and integer time.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [TW-1:0] t;
    logic [EW-1:0] d;
    logic [OW-1:0] o;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_time, m_tp, m_lcnt;

  function automatic int unsigned m_dist();
    return (m_time + TMOD - int'(mq[0].t)) % TMOD;
  endfunction

  function automatic bit m_due();
    if (mq.size() == 0) return 1'b0;
    return m_dist() < (TMOD / 2);
  endfunction

  function automatic bit m_late();
    return m_due() && (m_dist() != 0);
  endfunction

  // Snapshot of the DUT taken mid-cycle, for directed checks.
  logic          s_valid, s_late, s_pop, s_ready, s_empty, s_full;
  logic [EW-1:0] s_data;
  logic [OW-1:0] s_opr;
  logic [TW-1:0] s_time, s_sys;
  logic [7:0]    s_lcnt;

  task automatic drive(bit twv, int twd, bit ewv, int ewd, int opr, bit fl, bit rdy);
    twbck_i_valid  = twv;
    twbck_i_data   = TW'(twd);
    ewbck_i_valid  = ewv;
    ewbck_i_data   = EW'(ewd);
    ewbck_i_oprand = OW'(opr);
    flush_i        = fl;
    evt_o_ready    = rdy;
  endtask

  // One clock cycle: compare against the model at the falling edge, then
  // advance the model with the inputs that the rising edge sees.
  task automatic step();
    bit          e_valid, e_late, was_full;
    int unsigned tp_eff;
    ent_t        e;
    @(negedge clk);
    s_valid = evt_o_valid;  s_late  = evt_o_late;   s_data = evt_o_data;
    s_opr   = evt_o_oprand; s_time  = evt_o_time;   s_sys  = sys_time_o;
    s_lcnt  = late_cnt_o;   s_ready = ewbck_i_ready;
    s_empty = sched_empty;  s_full  = sched_full;
    s_pop   = evt_o_valid & evt_o_ready;

    e_valid = m_due() && !flush_i;
    e_late  = e_valid && m_late();
    chk("sys_time", s_sys, m_time);
    chk("evt_valid", s_valid, e_valid);
    chk("evt_late", s_late, e_late);
    chk("evt_data", s_data, (mq.size() > 0) ? mq[0].d : 0);
    chk("evt_oprand", s_opr, (mq.size() > 0) ? mq[0].o : 0);
    chk("evt_time", s_time, (mq.size() > 0) ? mq[0].t : 0);
    chk("late_cnt", s_lcnt, m_lcnt);
    chk("ewbck_ready", s_ready, mq.size() < DEPTH);
    chk("empty", s_empty, mq.size() == 0);
    chk("full", s_full, mq.size() == DEPTH);
    chk("twbck_ready", twbck_i_ready, 1);

    @(posedge clk);
    tp_eff   = twbck_i_valid ? int'(twbck_i_data) : m_tp;
    was_full = (mq.size() == DEPTH);
    if (flush_i) begin
      mq.delete();
    end else begin
      if (e_valid && evt_o_ready) begin
        if (e_late && m_lcnt < 255) m_lcnt++;
        void'(mq.pop_front());
      end
      if (ewbck_i_valid && !was_full) begin
        e.t = TW'(tp_eff);
        e.d = ewbck_i_data;
        e.o = ewbck_i_oprand;
        mq.push_back(e);
      end
    end
    if (twbck_i_valid) m_tp = twbck_i_data;
    m_time = (m_time + 1) % TMOD;
    #1;
  endtask

  // Asserts reset for part of a cycle; the cycle after release has sys_time 0.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #2;
    chk("rst_sys_time", sys_time_o, 0);
    chk("rst_valid", evt_o_valid, 0);
    chk("rst_late", evt_o_late, 0);
    chk("rst_empty", sched_empty, 1);
    chk("rst_full", sched_full, 0);
    chk("rst_late_cnt", late_cnt_o, 0);
    chk("rst_data", evt_o_data, 0);
    chk("rst_time", evt_o_time, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mq.delete();
    m_time = 0;
    m_tp   = 0;
    m_lcnt = 0;
  endtask

  typedef struct {
    bit       twv;
    int       twd;
    bit       ewv;
    int       ewd;
    int       opr;
    bit       exp_valid;
    bit       exp_late;
    int       exp_data;
    int       exp_opr;
    int       exp_time;
    int       exp_lcnt;
  } vec_t;

  vec_t tbl[13];
  int   stamps[4] = '{50, 20, 60, 70};
  int   pop_sys[$], pop_time[$], pop_late[$];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    do_reset();

    // Exact issue: twbck 10 in cycle 2, event in cycle 3, due only at 10.
    for (int i = 0; i < 13; i++) begin
      tbl[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    end
    tbl[2].twv = 1; tbl[2].twd = 10;
    tbl[3].ewv = 1; tbl[3].ewd = 'h1A5; tbl[3].opr = 5;
    tbl[10].exp_valid = 1; tbl[10].exp_data = 'h1A5;
    tbl[10].exp_opr = 5;   tbl[10].exp_time = 10;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].twv, tbl[i].twd, tbl[i].ewv, tbl[i].ewd, tbl[i].opr, 0, 1);
      step();
      chk("tbl_sys", s_sys, i);
      chk("tbl_valid", s_valid, tbl[i].exp_valid);
      chk("tbl_late", s_late, tbl[i].exp_late);
      chk("tbl_lcnt", s_lcnt, tbl[i].exp_lcnt);
      if (tbl[i].exp_valid) begin
        chk("tbl_data", s_data, tbl[i].exp_data);
        chk("tbl_opr", s_opr, tbl[i].exp_opr);
        chk("tbl_time", s_time, tbl[i].exp_time);
      end
    end

    // Forwarding (stamp 5 pushed at 3) and a late push (stamp 2 at 8).
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 3)      drive(1, 5, 1, 'h0F0, 1, 0, 1);
      else if (c == 8) drive(1, 2, 1, 'h02B, 2, 0, 1);
      else             drive(0, 0, 0, 0, 0, 0, 1);
      step();
      if (c == 4) chk("fwd_not_early", s_valid, 0);
      if (c == 5) begin
        chk("fwd_valid", s_valid, 1);
        chk("fwd_time", s_time, 5);
        chk("fwd_late", s_late, 0);
      end
      if (c == 9) begin
        chk("late_valid", s_valid, 1);
        chk("late_flag", s_late, 1);
        chk("late_time", s_time, 2);
      end
      if (c == 10) chk("late_cnt_1", s_lcnt, 1);
    end

    // Full queue and strict FIFO order.
    do_reset();
    for (int c = 0; c < 80; c++) begin
      if (c >= 1 && c <= 4) drive(1, stamps[c-1], 1, 'h100 + c, c, 0, 1);
      else                  drive(0, 0, 0, 0, 0, 0, 1);
      step();
      if (s_pop) begin
        pop_sys.push_back(int'(s_sys));
        pop_time.push_back(int'(s_time));
        pop_late.push_back(int'(s_late));
      end
      if (c == 5) begin
        chk("full_flag", s_full, 1);
        chk("full_ready", s_ready, 0);
      end
      if (c == 51) chk("ready_after_pop", s_ready, 1);
    end
    chk("order_npops", pop_sys.size(), 4);
    if (pop_sys.size() == 4) begin
      chk("order_sys0", pop_sys[0], 50);  chk("order_time0", pop_time[0], 50);
      chk("order_sys1", pop_sys[1], 51);  chk("order_time1", pop_time[1], 20);
      chk("order_late1", pop_late[1], 1);
      chk("order_sys2", pop_sys[2], 60);  chk("order_time2", pop_time[2], 60);
      chk("order_sys3", pop_sys[3], 70);  chk("order_time3", pop_time[3], 70);
    end
    chk("order_lcnt", late_cnt_o, 1);

    // Backpressure: stamp 30 held with ready low over 30..34.
    do_reset();
    for (int c = 0; c < 38; c++) begin
      if (c == 1) drive(1, 30, 1, 'h155, 6, 0, 1);
      else        drive(0, 0, 0, 0, 0, 0, !(c >= 30 && c < 35));
      step();
      if (c >= 30 && c <= 35) begin
        chk("bp_valid", s_valid, 1);
        chk("bp_data", s_data, 'h155);
        chk("bp_time", s_time, 30);
        chk("bp_late", s_late, c != 30);
      end
      if (c == 36) begin
        chk("bp_empty", s_empty, 1);
        chk("bp_lcnt", s_lcnt, 1);
      end
    end

    // Flush with a simultaneous push; the flush-cycle twbck still lands.
    for (int c = 38; c < 48; c++) begin
      if (c >= 40 && c <= 42) drive(1, 120, 1, c, 3, 0, 1);
      else if (c == 43)       drive(1, 99, 1, 'h3C, 4, 1, 1);
      else if (c == 44)       drive(0, 0, 1, 'h77, 7, 0, 1);
      else                    drive(0, 0, 0, 0, 0, 0, 1);
      step();
      if (c == 43) chk("flush_pre_empty", s_empty, 0);
      if (c == 44) begin
        chk("flush_empty", s_empty, 1);
        chk("flush_valid", s_valid, 0);
      end
      if (c == 45) chk("flush_tp_taken", s_time, 99);
    end

    // Wrap: stamp 0x01 pushed at 0xFE issues at 0x01, not late.
    for (int c = 48; c < 258; c++) begin
      if (c == 254) drive(1, 1, 1, 'h1FFFFF, 2, 0, 1);
      else          drive(0, 0, 0, 0, 0, 0, 1);
      step();
      if (c == 255 || c == 256) chk("wrap_not_early", s_valid, 0);
      if (c == 257) begin
        chk("wrap_sys", s_sys, 1);
        chk("wrap_valid", s_valid, 1);
        chk("wrap_late", s_late, 0);
        chk("wrap_time", s_time, 1);
      end
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int twd;
      if ($urandom_range(0, 15) == 0) twd = int'($urandom_range(0, TMOD - 1));
      else twd = int'((m_time + $urandom_range(0, 24) + TMOD - 10) % TMOD);
      drive($urandom_range(0, 9) < 3, twd, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, (1 << EW) - 1)), int'($urandom_range(0, 7)),
            $urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
